// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types for the packet arbiter: FSM state encoding.
package axis_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin pick: first asserted request searching upward from ptr+1.
module axis_rr_select #(
  parameter int INPUTS    = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [INPUTS-1:0]    req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 gnt_vld
);

  logic [IDX_WIDTH-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = INPUTS; k >= 1; k--) begin
      idx = IDX_WIDTH'((int'(ptr) + k) % INPUTS);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter: grants whole packets of cfg_data+1 beats,
// generates tlast and tags each beat with its source index on tuser.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int INPUTS           = 4,
  parameter int IDX_WIDTH        = 2
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [CNTR_WIDTH-1:0]              cfg_data,
  output logic [CNTR_WIDTH-1:0]              sts_data,
  output logic [INPUTS-1:0]                  s_axis_tready,
  input  logic [INPUTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [INPUTS-1:0]                  s_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [IDX_WIDTH-1:0]               m_axis_tuser
);

  state_e                state_q;
  logic [IDX_WIDTH-1:0]  grant_q;
  logic [IDX_WIDTH-1:0]  ptr_q;
  logic [CNTR_WIDTH-1:0] cnt_q;
  logic [CNTR_WIDTH-1:0] len_q;
  logic [CNTR_WIDTH-1:0] sts_q;

  logic [IDX_WIDTH-1:0]  pick_idx;
  logic                  pick_vld;
  logic                  granted;
  logic                  hs;

  axis_rr_select #(
    .INPUTS    (INPUTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_select (
    .req     (s_axis_tvalid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign granted       = (state_q == ST_GRANT);
  assign m_axis_tdata  = s_axis_tdata[grant_q*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
  assign m_axis_tvalid = granted & s_axis_tvalid[grant_q];
  assign m_axis_tlast  = granted & (cnt_q == len_q);
  assign m_axis_tuser  = grant_q;
  assign sts_data      = sts_q;
  assign hs            = m_axis_tvalid & m_axis_tready;

  // Only the granted input sees downstream ready; everyone else is held off.
  always_comb begin
    s_axis_tready = '0;
    if (granted) s_axis_tready[grant_q] = m_axis_tready;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_WIDTH'(INPUTS - 1);
      cnt_q   <= '0;
      len_q   <= '0;
      sts_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            ptr_q   <= pick_idx;
            len_q   <= cfg_data;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (hs) begin
            if (m_axis_tlast) begin
              cnt_q   <= '0;
              sts_q   <= sts_q + 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed scoreboard bench for axis_packet_arbiter (INPUTS=4, 32-bit beats).
module tb_axis_packet_arbiter;

  localparam int W  = 32;
  localparam int CW = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [IW-1:0] user;
    logic          last;
  } beat_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [CW-1:0]   cfg_data = '0;
  logic [CW-1:0]   sts_data;
  logic [N-1:0]    s_tready;
  logic [N*W-1:0]  s_tdata = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic            m_tready = 1'b1;
  logic [W-1:0]    m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [IW-1:0]   m_tuser;

  beat_t       exp_q[$];
  int unsigned drv_seq[N];
  int unsigned exp_seq[N];
  int          checks = 0;
  int          errors = 0;

  axis_packet_arbiter #(
    .AXIS_TDATA_WIDTH (W),
    .CNTR_WIDTH       (CW),
    .INPUTS           (N),
    .IDX_WIDTH        (IW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .sts_data      (sts_data),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Each source emits {index, running sequence number}.
  task automatic drive_data();
    for (int i = 0; i < N; i++)
      s_tdata[i*W +: W] = {8'(i), drv_seq[i][23:0]};
  endtask

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.data = {8'(src), exp_seq[src][23:0]};
      b.user = IW'(src);
      b.last = (k == len);
      exp_q.push_back(b);
      exp_seq[src]++;
    end
  endtask

  task automatic tick();
    beat_t e;
    @(negedge aclk);
    if (m_tvalid && m_tready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tdata", 64'(m_tdata), 64'(e.data));
        chk("tuser", 64'(m_tuser), 64'(e.user));
        chk("tlast", 64'(m_tlast), 64'(e.last));
      end
    end
    if (!m_tready) chk("stall_ready", 64'(s_tready), 64'd0);
    for (int i = 0; i < N; i++)
      if (s_tvalid[i] && s_tready[i]) drv_seq[i]++;
    @(posedge aclk);
    #1;
    drive_data();
  endtask

  task automatic run_until(input int target, input int budget, input bit toggle, output int n);
    n = 0;
    while (exp_q.size() > target && n < budget) begin
      tick();
      n++;
      if (toggle) m_tready = ~m_tready;
    end
    chk("timeout", 64'(exp_q.size() > target), 64'd0);
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b1;
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_sts", 64'(sts_data), 64'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      drv_seq[i] = 0;
      exp_seq[i] = 0;
    end
    drive_data();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int n;

    // Test 1: single requester, 4-beat packets, one bubble between packets
    do_reset();
    cfg_data = 3;
    s_tvalid = 4'b0100;
    repeat (3) push_pkt(2, 3);
    run_until(0, 100, 1'b0, n);
    s_tvalid = '0;
    chk("t1_cycles", 64'(n), 64'd15);
    tick(); tick();
    chk("t1_sts", 64'(sts_data), 64'd3);

    // Test 2: all inputs requesting, round-robin order 0,1,2,3,0
    do_reset();
    cfg_data = 1;
    s_tvalid = 4'b1111;
    push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1); push_pkt(0, 1);
    run_until(0, 100, 1'b0, n);
    s_tvalid = '0;
    tick(); tick();
    chk("t2_sts", 64'(sts_data), 64'd5);

    // Test 3: one-beat packets alternating between inputs 1 and 3
    do_reset();
    cfg_data = 0;
    s_tvalid = 4'b1010;
    push_pkt(1, 0); push_pkt(3, 0); push_pkt(1, 0); push_pkt(3, 0);
    run_until(0, 100, 1'b0, n);
    s_tvalid = '0;
    tick(); tick();
    chk("t3_sts", 64'(sts_data), 64'd4);

    // Test 4: downstream ready toggling during an 8-beat packet
    do_reset();
    cfg_data = 7;
    s_tvalid = 4'b0001;
    m_tready = 1'b1;
    push_pkt(0, 7);
    run_until(0, 200, 1'b1, n);
    s_tvalid = '0;
    m_tready = 1'b1;
    tick(); tick();
    chk("t4_sts", 64'(sts_data), 64'd1);

    // Test 5: cfg_data shrinks mid-packet, only the next packet is affected
    s_tvalid = 4'b0001;
    push_pkt(0, 7);
    push_pkt(0, 2);
    run_until(8, 100, 1'b0, n);
    cfg_data = 2;
    run_until(0, 100, 1'b0, n);
    s_tvalid = '0;
    tick(); tick();
    chk("t5_sts", 64'(sts_data), 64'd3);

    // Test 6: asynchronous reset at beat 5 of 8, then restart from input 0
    do_reset();
    cfg_data = 7;
    s_tvalid = 4'b0001;
    push_pkt(0, 7);
    run_until(4, 100, 1'b0, n);
    chk("t6_pre_tvalid", 64'(m_tvalid), 64'd1);
    #3;
    aresetn = 1'b0;
    #1;
    chk("t6_async_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_async_tready", 64'(s_tready), 64'd0);
    chk("t6_async_sts", 64'(sts_data), 64'd0);
    do_reset();
    chk("t6_post_sts", 64'(sts_data), 64'd0);
    cfg_data = 1;
    s_tvalid = 4'b0101;
    push_pkt(0, 1); push_pkt(2, 1);
    run_until(0, 100, 1'b0, n);
    s_tvalid = '0;
    tick(); tick();
    chk("t6_sts", 64'(sts_data), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
